tt_sweep_checker: RTL and testbench

- Sequential stimulus/capture stage that sits directly upstream and downstream of a 3-input combinational logic design (e.g. the 0x65 gate netlist).
- Drives the design's in1/in2/in3 through all 8 input rows, waits a settle window per row, samples the design's out, and assembles the observed 8-bit truth table.
- Compares the observed table against an expected table and reports pass/fail plus a per-row mismatch mask.
- Used for on-chip/bench characterisation of the generated 3-input designs.

---
 rtl/tt_sweep_checker.sv | 128 ++++++++++++
 tb/tb_tt_sweep_checker.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker: sweeps a 3-input combinational design through all 8 rows,
// captures its output per row into an 8-bit truth table (row r -> bit 7-r),
// and compares against EXPECTED_TT.
// Optional: define TT_STABILITY_CHECK_EN to also flag rows whose output
// changed between the mid-window sample and the final sample.
module tt_sweep_checker #(
    parameter logic [7:0] EXPECTED_TT   = 8'h65,
    parameter int         SETTLE_CYCLES = 4,
    parameter int         CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_out,
    output logic       drv_in1,
    output logic       drv_in2,
    output logic       drv_in3,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] observed_tt,
    output logic [7:0] mismatch_mask,
    output logic [7:0] unstable_mask
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES);

    logic [1:0]       state;
    logic [2:0]       row;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       row_bit;
    logic             row_end;
    logic             sweep_go;
    logic [7:0]       tt_next;
    logic [7:0]       um_next;

    // Row r lands in bit 7-r so row 0 is the MSB of the table.
    assign row_bit  = 8'h80 >> row;
    assign row_end  = (state == ST_SETTLE) && (cnt == CNT_LAST);
    assign sweep_go = (state == ST_IDLE) && start;
    assign tt_next  = (observed_tt & ~row_bit) | (dut_out ? row_bit : 8'h00);

    assign {drv_in1, drv_in2, drv_in3} = (state == ST_SETTLE) ? row : 3'b000;
    assign busy = (state == ST_SETTLE);
    assign done = (state == ST_DONE);

`ifdef TT_STABILITY_CHECK_EN
    localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(SETTLE_CYCLES / 2);

    logic mid_q;

    assign um_next = unstable_mask | ((mid_q != dut_out) ? row_bit : 8'h00);

    // Mid-window sample of the current row, compared against the final sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mid_q <= 1'b0;
        else if (state == ST_SETTLE && cnt == CNT_MID)
            mid_q <= dut_out;
    end

    // Accumulate per-row instability flags; cleared when a sweep begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            unstable_mask <= 8'h00;
        else if (sweep_go)
            unstable_mask <= 8'h00;
        else if (row_end)
            unstable_mask <= um_next;
    end
`else
    assign um_next       = 8'h00;
    assign unstable_mask = 8'h00;
`endif

    // Sweep FSM: row/settle counters, table capture and result publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            row           <= 3'd0;
            cnt           <= '0;
            observed_tt   <= 8'h00;
            mismatch_mask <= 8'h00;
            pass          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state         <= ST_SETTLE;
                        row           <= 3'd0;
                        cnt           <= '0;
                        observed_tt   <= 8'h00;
                        mismatch_mask <= 8'h00;
                        pass          <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        observed_tt <= tt_next;
                        cnt         <= '0;
                        if (row == 3'd7) begin
                            // Last row: publish compare results with the final bit included.
                            state         <= ST_DONE;
                            mismatch_mask <= tt_next ^ EXPECTED_TT;
                            pass          <= (tt_next == EXPECTED_TT) && (um_next == 8'h00);
                        end else begin
                            row <= row + 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    row   <= 3'd0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: directed sweeps against a reference 3-input
// model, a stuck-at-0 model and a 3-cycle-delayed model, with a scoreboard of
// expected results pushed at start and popped on done.
module tb_tt_sweep_checker;

    localparam logic [7:0] EXP_TT = 8'h65;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       dut_out;
    logic       drv_in1, drv_in2, drv_in3;
    logic       busy, done, pass;
    logic [7:0] observed_tt, mismatch_mask, unstable_mask;

    int         mode = 0;
    logic [2:0] drv;
    logic [2:0] d1 = 3'd0, d2 = 3'd0, d3 = 3'd0;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] tt;
        logic [7:0] mm;
        logic [7:0] um;
        logic       pass;
    } exp_t;

    exp_t sb[$];

    tt_sweep_checker #(
        .EXPECTED_TT  (EXP_TT),
        .SETTLE_CYCLES(4),
        .CNT_W        (8)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .dut_out      (dut_out),
        .drv_in1      (drv_in1),
        .drv_in2      (drv_in2),
        .drv_in3      (drv_in3),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .observed_tt  (observed_tt),
        .mismatch_mask(mismatch_mask),
        .unstable_mask(unstable_mask)
    );

    always #5 clk = ~clk;

    function automatic logic ref_f(input logic [2:0] r);
        return (~r[2] & r[1]) ^ r[0];
    endfunction

    assign drv = {drv_in1, drv_in2, drv_in3};

    // Delay line for the slow-settling model.
    always @(posedge clk) begin
        d1 <= drv;
        d2 <= d1;
        d3 <= d2;
    end

    assign dut_out = (mode == 1) ? 1'b0 : (mode == 2) ? ref_f(d3) : ref_f(drv);

    function automatic exp_t predict(input int m);
        exp_t e;
        e.tt = 8'h00;
        e.um = 8'h00;
        for (int r = 0; r < 8; r++) begin
            logic [2:0] rr;
            logic [2:0] pr;
            rr = r[2:0];
            pr = (r == 0) ? 3'd0 : rr - 3'd1;
            if (m != 1) e.tt[7-r] = ref_f(rr);
`ifdef TT_STABILITY_CHECK_EN
            if (m == 2 && ref_f(rr) != ref_f(pr)) e.um[7-r] = 1'b1;
`else
            if (pr == rr) e.um = 8'h00;
`endif
        end
        e.mm   = e.tt ^ EXP_TT;
        e.pass = (e.tt == EXP_TT) && (e.um == 8'h00);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sweep(input string tag, input int m, input bit extra);
        exp_t e;
        int   bad;
        sb.push_back(predict(m));
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, ".clr_tt"}, 32'(observed_tt), 32'h00);
        check({tag, ".clr_mm"}, 32'(mismatch_mask), 32'h00);
        check({tag, ".clr_pass"}, 32'(pass), 32'h0);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            if (drv !== 3'(k / 5) || busy !== 1'b1 || done !== 1'b0) bad++;
            start = (extra && k == 9);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check({tag, ".seq_bad_cycles"}, 32'(bad), 32'd0);
        check({tag, ".done_hi"}, 32'(done), 32'h1);
        check({tag, ".busy_lo"}, 32'(busy), 32'h0);
        check({tag, ".drv_done"}, 32'(drv), 32'h0);
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s.sb_empty: observed 0 entries, expected 1", tag);
            e = predict(m);
        end else begin
            e = sb.pop_front();
            check({tag, ".observed_tt"}, 32'(observed_tt), 32'(e.tt));
            check({tag, ".mismatch_mask"}, 32'(mismatch_mask), 32'(e.mm));
            check({tag, ".unstable_mask"}, 32'(unstable_mask), 32'(e.um));
            check({tag, ".pass"}, 32'(pass), 32'(e.pass));
        end
        start = extra;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, ".done_pulse"}, 32'(done), 32'h0);
        check({tag, ".idle_busy"}, 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        check({tag, ".no_restart"}, 32'(busy), 32'h0);
        check({tag, ".hold_tt"}, 32'(observed_tt), 32'(e.tt));
        check({tag, ".hold_pass"}, 32'(pass), 32'(e.pass));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", 32'(busy), 32'h0);
        check("rst.done", 32'(done), 32'h0);
        check("rst.pass", 32'(pass), 32'h0);
        check("rst.drv", 32'(drv), 32'h0);
        check("rst.tt", 32'(observed_tt), 32'h0);
        check("rst.mm", 32'(mismatch_mask), 32'h0);
        check("rst.um", 32'(unstable_mask), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        sweep("ref", 0, 1'b0);
        sweep("tied0", 1, 1'b0);
        sweep("ignore", 0, 1'b1);

        // Abort a sweep with an asynchronous reset mid-cycle.
        @(negedge clk);
        mode  = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        check("abort.partial_tt", 32'(observed_tt), 32'h60);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort.busy", 32'(busy), 32'h0);
        check("abort.done", 32'(done), 32'h0);
        check("abort.pass", 32'(pass), 32'h0);
        check("abort.drv", 32'(drv), 32'h0);
        check("abort.tt", 32'(observed_tt), 32'h0);
        check("abort.mm", 32'(mismatch_mask), 32'h0);
        check("abort.um", 32'(unstable_mask), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        sweep("after_rst", 0, 1'b0);
        sweep("delay3", 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
